// File: rtl/ps2_host_tx_if.sv
// CPU-side byte handshake for the PS/2 host transmitter.
// master = CPU driving requests, slave = ps2_host_tx.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;

    modport master (
        output tx_valid, tx_data,
        input  tx_ready, tx_done, tx_error
    );

    modport slave (
        input  tx_valid, tx_data,
        output tx_ready, tx_done, tx_error
    );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, device-clocked frame, ACK check.
// Define PS2_HOST_TX_RETRY_EN to retry once on NACK/timeout before reporting an error.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 2500,
    parameter int unsigned TIMEOUT_CYCLES = 375000
) (
    input  logic         CLK,
    input  logic         reset,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);

    localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                       : TIMEOUT_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0] InhLast = CntW'(INHIBIT_CYCLES - 1);
    localparam logic [CntW-1:0] ToLast  = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle, StInhibit, StReq, StSend, StAck, StRelease, StFail
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [10:0]     shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            parity_q, parity_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [1:0]      clk_sync_q, data_sync_q;
    logic            clk_prev_q;
    logic            clk_s, data_s, fall;
    logic            timing, fail;
`ifdef PS2_HOST_TX_RETRY_EN
    logic            retry_q, retry_d;
`endif

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];
    assign fall   = clk_prev_q & ~clk_s;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '1;
            byte_q      <= '0;
            parity_q    <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_q      <= byte_d;
            parity_q    <= parity_d;
            done_q      <= done_d;
            error_q     <= error_d;
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
            data_sync_q <= {data_sync_q[0], ps2_data_in};
            clk_prev_q  <= clk_s;
`ifdef PS2_HOST_TX_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        parity_d  = parity_q;
        done_d    = 1'b0;
        error_d   = 1'b0;
        fail      = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        retry_d   = retry_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (tx.tx_valid) begin
                    byte_d    = tx.tx_data;
                    parity_d  = ~^tx.tx_data;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StInhibit;
`ifdef PS2_HOST_TX_RETRY_EN
                    retry_d   = 1'b0;
`endif
                end
            end
            StInhibit: begin
                if (cnt_q == InhLast) begin
                    cnt_d   = '0;
                    // Frame LSB-first: start, data[0..7], parity, stop.
                    shift_d = {1'b1, parity_q, byte_q, 1'b0};
                    state_d = StReq;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReq: begin
                cnt_d   = cnt_q + CntW'(1);
                state_d = StSend;
            end
            StSend: begin
                cnt_d = cnt_q + CntW'(1);
                if (fall) begin
                    shift_d   = {1'b1, shift_q[10:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                cnt_d = cnt_q + CntW'(1);
                if (fall) begin
                    state_d = data_s ? StFail : StRelease;
                end
            end
            StRelease: begin
                cnt_d = cnt_q + CntW'(1);
                if (clk_s && data_s) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            StFail: begin
                fail = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        timing = (state_q == StReq) || (state_q == StSend) ||
                 (state_q == StAck) || (state_q == StRelease);
        if (timing && (cnt_q == ToLast)) begin
            fail = 1'b1;
        end

        // Failure overrides whatever the state logic chose this cycle.
        if (fail) begin
            done_d = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            if (!retry_q) begin
                retry_d   = 1'b1;
                cnt_d     = '0;
                bit_cnt_d = '0;
                state_d   = StInhibit;
            end else begin
                state_d = StIdle;
                error_d = 1'b1;
            end
`else
            state_d = StIdle;
            error_d = 1'b1;
`endif
        end
    end

    assign tx.tx_ready = (state_q == StIdle);
    assign tx.tx_done  = done_q;
    assign tx.tx_error = error_q;

    assign ps2_clk_oe  = (state_q == StInhibit) || (state_q == StReq);
    assign ps2_data_oe = ((state_q == StReq) || (state_q == StSend)) ? ~shift_q[0] : 1'b0;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
// Expected frames come from a parity/bit-order reference function, not the RTL.
module tb_ps2_host_tx;

    localparam int unsigned INH = 20;
    localparam int unsigned TO  = 1000;

    logic CLK      = 1'b0;
    logic reset    = 1'b0;
    logic dev_clk  = 1'b1;
    logic dev_data = 1'b1;
    logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;

    ps2_host_tx_if txif ();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK        (CLK),
        .reset      (reset),
        .tx         (txif),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    // Wired-AND open-drain lines.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 CLK = ~CLK;

    int n_total  = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int viol_cnt = 0;

    always @(negedge CLK) begin
        if (reset) begin
            if (txif.tx_done)  done_cnt <= done_cnt + 1;
            if (txif.tx_error) err_cnt  <= err_cnt + 1;
            if ((txif.tx_done && txif.tx_error) ||
                (txif.tx_ready && (ps2_clk_oe || ps2_data_oe)))
                viol_cnt <= viol_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0]  data;
        bit          hold_ff;
        logic [10:0] exp_frame;
        int          exp_inh;
        int          exp_req;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Line-level frame: {stop, parity, data[7:0], start}, odd parity.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] d, input bit hold_ff);
        check("accept_ready", 32'(txif.tx_ready), 32'd1);
        txif.tx_valid = 1'b1;
        txif.tx_data  = d;
        @(negedge CLK);
        if (hold_ff) txif.tx_data = 8'hFF;
        else txif.tx_valid = 1'b0;
    endtask

    // Device side: observe inhibit/RTS, clock 11 falls, sample bits, ACK or NACK.
    task automatic device_frame(input bit ack, input int stop_after, output logic [10:0] bits,
                                output int inh_len, output int req_idx, output bit ok);
        int t;
        ok = 1'b1; inh_len = 0; req_idx = -1; bits = '0; t = 0;
        while (!ps2_clk_oe && t < 100) begin
            @(negedge CLK);
            t++;
        end
        if (!ps2_clk_oe) begin
            ok = 1'b0;
            return;
        end
        while (ps2_clk_oe && inh_len < 400) begin
            if (ps2_data_oe && req_idx < 0) req_idx = inh_len;
            inh_len++;
            @(negedge CLK);
        end
        if (ps2_clk_oe) begin
            ok = 1'b0;
            return;
        end
        repeat (3) @(negedge CLK);
        bits[0] = ps2_data_in;
        for (int k = 1; k <= 11; k++) begin
            if (k == 11) begin
                dev_data = ack ? 1'b0 : 1'b1;
                repeat (4) @(negedge CLK);
            end
            dev_clk = 1'b0;
            repeat (8) @(negedge CLK);
            if (k <= 10) bits[k] = ps2_data_in;
            if (k == stop_after) return;
            repeat (2) @(negedge CLK);
            dev_clk = 1'b1;
            repeat (10) @(negedge CLK);
        end
        dev_data = 1'b1;
    endtask

    task automatic finish_frame(input string name, input int d0, input int e0,
                                input int exp_done, input int exp_err);
        int t;
        t = 0;
        while ((done_cnt - d0) + (err_cnt - e0) == 0 && t < 100) begin
            @(negedge CLK);
            t++;
        end
        repeat (4) @(negedge CLK);
        check({name, "_done"}, 32'(done_cnt - d0), 32'(exp_done));
        check({name, "_err"}, 32'(err_cnt - e0), 32'(exp_err));
        check({name, "_idle"}, {29'd0, txif.tx_ready, ps2_clk_oe, ps2_data_oe}, 32'b100);
    endtask

    initial begin
        logic [10:0] bits;
        logic [7:0]  d;
        int          inh, req, d0, e0, idx, t;
        bit          ok, seen;

        vecs[0] = '{data: 8'hED, hold_ff: 1'b0, exp_frame: 11'h7DA, exp_inh: INH + 1, exp_req: INH};
        vecs[1] = '{data: 8'h00, hold_ff: 1'b1, exp_frame: 11'h600, exp_inh: INH + 1, exp_req: INH};
        vecs[2] = '{data: 8'hFF, hold_ff: 1'b0, exp_frame: 11'h7FE, exp_inh: INH + 1, exp_req: INH};
        vecs[3] = '{data: 8'hF4, hold_ff: 1'b0, exp_frame: 11'h5E8, exp_inh: INH + 1, exp_req: INH};

        txif.tx_valid = 1'b0;
        txif.tx_data  = 8'h00;
        repeat (3) @(negedge CLK);
        check("rst_ready", 32'(txif.tx_ready), 32'd1);
        check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("rst_pulses", {30'd0, txif.tx_done, txif.tx_error}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge CLK);

        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt; e0 = err_cnt;
            send_byte(vecs[i].data, vecs[i].hold_ff);
            device_frame(1'b1, 0, bits, inh, req, ok);
            txif.tx_valid = 1'b0;
            check("vec_rts", 32'(ok), 32'd1);
            check("vec_frame", 32'(bits), 32'(vecs[i].exp_frame));
            check("vec_inhibit_len", 32'(inh), 32'(vecs[i].exp_inh));
            check("vec_req_idx", 32'(req), 32'(vecs[i].exp_req));
            finish_frame("vec", d0, e0, 1, 0);
            repeat (10) @(negedge CLK);
            check("vec_no_extra", {30'd0, txif.tx_ready, ps2_clk_oe}, 32'b10);
        end

        for (int i = 0; i < 6; i++) begin
            d = 8'($urandom_range(0, 255));
            d0 = done_cnt; e0 = err_cnt;
            send_byte(d, 1'b0);
            device_frame(1'b1, 0, bits, inh, req, ok);
            check("rand_frame", 32'(bits), 32'(ref_frame(d)));
            finish_frame("rand", d0, e0, 1, 0);
        end

        // NACK
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hF0, 1'b0);
        device_frame(1'b0, 0, bits, inh, req, ok);
        check("nack_frame", 32'(bits), 32'(ref_frame(8'hF0)));
`ifdef PS2_HOST_TX_RETRY_EN
        device_frame(1'b1, 0, bits, inh, req, ok);
        check("retry_rts", 32'(ok), 32'd1);
        check("retry_frame", 32'(bits), 32'(ref_frame(8'hF0)));
        finish_frame("nack_retry", d0, e0, 1, 0);
`else
        finish_frame("nack", d0, e0, 0, 1);
`endif

        // Timeout: device never clocks; measure from the last REQ cycle.
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h55, 1'b0);
        idx = -1; t = 0;
        while (!txif.tx_error && t < 3000) begin
            if (ps2_clk_oe && ps2_data_oe) idx = 0;
            else if (idx >= 0) idx++;
            @(negedge CLK);
            t++;
        end
        if (idx >= 0) idx++;
        check("timeout_cycles", 32'(idx), 32'(TO));
        check("timeout_state", {29'd0, txif.tx_ready, ps2_clk_oe, ps2_data_oe}, 32'b100);
        finish_frame("timeout", d0, e0, 0, 1);

        // Asynchronous reset mid-frame after fall 4 (bit 3 of 0x00 drives data low).
        send_byte(8'h00, 1'b0);
        device_frame(1'b1, 4, bits, inh, req, ok);
        check("pre_rst_data_oe", 32'(ps2_data_oe), 32'd1);
        #1 reset = 1'b0;
        #1 check("async_rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        dev_clk = 1'b1;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        check("post_rst_ready", 32'(txif.tx_ready), 32'd1);
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'hFF, 1'b0);
        device_frame(1'b1, 0, bits, inh, req, ok);
        check("post_rst_frame", 32'(bits), 32'(ref_frame(8'hFF)));
        finish_frame("post_rst", d0, e0, 1, 0);

        // Back-to-back: valid held through the done cycle.
        d0 = done_cnt; e0 = err_cnt;
        send_byte(8'h3C, 1'b0);
        device_frame(1'b1, 0, bits, inh, req, ok);
        check("b2b_frame1", 32'(bits), 32'(ref_frame(8'h3C)));
        txif.tx_valid = 1'b1;
        txif.tx_data  = 8'hF4;
        seen = 1'b0; t = 0;
        while (!seen && t < 60) begin
            @(negedge CLK);
            seen = txif.tx_done;
            t++;
        end
        check("b2b_done_seen", 32'(seen), 32'd1);
        @(negedge CLK);
        check("b2b_inhibit", {30'd0, txif.tx_ready, ps2_clk_oe}, 32'b01);
        txif.tx_valid = 1'b0;
        device_frame(1'b1, 0, bits, inh, req, ok);
        check("b2b_frame2", 32'(bits), 32'h5E8);
        finish_frame("b2b", d0, e0, 2, 0);

        check("exclusive_idle_lines", 32'(viol_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
